mor1kx_rf_wb_sequencer_cappuccino: RTL and testbench
====================================================

// Module: mor1kx_rf_wb_sequencer_cappuccino
// PURPOSE
//  Writeback-side producer for the cappuccino GPR file: merges execute-stage (ALU) results and
//  delayed load data onto the single RF write port (we/addr/data). Holds a 1-entry skid buffer
//  for ALU results displaced by load returns. Tracks the one outstanding load destination and
//  raises a decode stall on RAW/WAW hazards against it. Sits between execute/LSU and the RF.
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32  data width of results and RF write data
//  OPTION_RF_ADDR_WIDTH  5   GPR address width; address 0 is r0 (never written)
// PORTS
//  clk             in   1    clock
//  rst             in   1    reset: synchronous, active-high
//  exec_valid_i    in   1    ALU result valid this cycle
//  exec_rfd_i      in   AW   ALU result destination GPR
//  exec_result_i   in   W    ALU result data
//  exec_ready_o    out  1    ALU result accepted when exec_valid_i & exec_ready_o
//  lsu_issue_i     in   1    load issued; reserve destination lsu_rfd_i
//  lsu_rfd_i       in   AW   load destination GPR (sampled on lsu_issue_i)
//  lsu_valid_i     in   1    load data returning this cycle
//  lsu_data_i      in   W    load data
//  lsu_busy_o      out  1    a load is outstanding (pending flag)
//  dec_rfa_adr_i   in   AW   decode operand A address
//  dec_rfb_adr_i   in   AW   decode operand B address
//  dec_rfa_used_i  in   1    decode uses operand A
//  dec_rfb_used_i  in   1    decode uses operand B
//  stall_o         out  1    decode must hold (combinational)
//  rf_we_o         out  1    RF write enable (registered)
//  rf_wad_o        out  AW   RF write address (registered)
//  rf_wdat_o       out  W    RF write data (registered)
// BEHAVIOUR
//  - Reset: rf_we_o=0, rf_wad_o=0, rf_wdat_o=0, pending=0, pend_rfd=0, skid empty;
//    hence lsu_busy_o=0, stall_o=0, exec_ready_o=1 the cycle after rst.
//  - Latency: a write source selected in cycle N appears on rf_we_o/wad/wdat in cycle N+1,
//    for exactly one cycle. rf_we_o=0 in any cycle with no selected source.
//  - Selection per cycle, priority: (1) lsu_valid_i & pending, (2) skid entry, (3) accepted exec.
//  - exec_ready_o = !skid_full & !(pending & exec_rfd_i==pend_rfd & exec_rfd_i!=0) [WAW block].
//  - Accepted exec goes straight to the write register if nothing of higher priority is selected;
//    otherwise it goes into the skid. The skid drains before any later exec, so order is preserved.
//  - r0: a selected write with address 0 completes its handshake, but rf_we_o stays 0.
//    lsu_issue_i with rfd=0 does not set pending.
//  - Load FSM IDLE->PEND on lsu_issue_i (rfd!=0), latching pend_rfd. PEND->IDLE on lsu_valid_i.
//    lsu_valid_i & lsu_issue_i in the same cycle while PEND: old data is written, the new rfd is
//    latched, and the FSM stays PEND.
//  - lsu_issue_i while PEND without lsu_valid_i: protocol violation; ignored (pend_rfd kept).
//  - lsu_valid_i in IDLE: ignored (no write).
//  - stall_o = used & adr!=0 & adr matches pend_rfd (when pending) or the skid rfd (when skid_full),
//    evaluated for operand A or B.
//  - rst asserted mid-load: pending and skid are cleared, the in-flight write is dropped, and a
//    later lsu_valid_i is ignored.
// TESTING
//  - exec_valid,rfd=3,res=0x1234 @N -> rf_we=1,wad=3,wdat=0x1234 @N+1 only; ready stays 1.
//  - issue load rfd=5; exec rfd=7 res=0xA @N together with lsu_valid data=0xB @N
//    -> N+1 we r5=0xB, N+2 we r7=0xA; exec_ready=0 @N+1.
//  - pending rfd=5; decode rfa=5, used -> stall=1; rfa=5 with used=0 -> stall=0;
//    after the data write, stall=0.
//  - pending rfd=5; exec rfd=5 -> ready=0 until lsu_valid; writes land r5=load, then r5=exec.
//  - exec rfd=0 -> ready=1, rf_we stays 0; lsu_issue rfd=0 -> lsu_busy stays 0.
//  - rst during PEND then lsu_valid -> no write, lsu_busy=0, all outputs at reset values.

Source files
------------

// File: rtl/mor1kx_rf_wb_sequencer_cappuccino.sv
// Writeback sequencer: merges ALU results and load returns onto the single GPR write port.
// Latency: a source selected in cycle N drives rf_we_o/rf_wad_o/rf_wdat_o in cycle N+1.
// Backpressure: exec_ready_o drops while the skid holds a displaced ALU result or on a WAW hit
// against the outstanding load destination.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   exec_valid_i/rfd/result, ready  ALU result handshake
//   lsu_issue_i/rfd, lsu_valid_i/data, lsu_busy_o   single outstanding load tracking
//   dec_rf{a,b}_adr_i/used_i, stall_o              decode hazard check (combinational)
//   rf_we_o/rf_wad_o/rf_wdat_o      registered GPR write port
module mor1kx_rf_wb_sequencer_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            exec_valid_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] exec_result_i,
    output logic                            exec_ready_o,

    input  logic                            lsu_issue_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_rfd_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_data_i,
    output logic                            lsu_busy_o,

    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dec_rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dec_rfb_adr_i,
    input  logic                            dec_rfa_used_i,
    input  logic                            dec_rfb_used_i,
    output logic                            stall_o,

    output logic                            rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wad_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o
);

    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam logic [AW-1:0] R0 = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } load_state_t;

    load_state_t   state, state_nxt;
    logic [AW-1:0] pend_rfd, pend_rfd_nxt;
    logic          pending;

    logic          skid_full, skid_full_nxt;
    logic [AW-1:0] skid_rfd, skid_rfd_nxt;
    logic [W-1:0]  skid_dat, skid_dat_nxt;

    logic          load_sel;
    logic          exec_acc;
    logic          sel;
    logic [AW-1:0] sel_wad;
    logic [W-1:0]  sel_wdat;

    assign pending    = (state == PEND);
    assign lsu_busy_o = pending;

    // An ALU result to the register the outstanding load will write must wait, otherwise
    // the late load data would overwrite the younger ALU result.
    assign exec_ready_o = !skid_full &&
                          !(pending && (exec_rfd_i == pend_rfd) && (exec_rfd_i != R0));
    assign exec_acc     = exec_valid_i && exec_ready_o;
    assign load_sel     = lsu_valid_i && pending;

    function automatic logic hazard(input logic used, input logic [AW-1:0] adr,
                                    input logic pend, input logic [AW-1:0] prfd,
                                    input logic sfull, input logic [AW-1:0] srfd);
        return used && (adr != R0) &&
               ((pend && (adr == prfd)) || (sfull && (adr == srfd)));
    endfunction

    assign stall_o = hazard(dec_rfa_used_i, dec_rfa_adr_i, pending, pend_rfd, skid_full, skid_rfd) ||
                     hazard(dec_rfb_used_i, dec_rfb_adr_i, pending, pend_rfd, skid_full, skid_rfd);

    // Write-port selection and skid management. The skid only fills when an accepted ALU
    // result collides with a load return; since exec_ready_o is low while it is full, it
    // always drains before any younger ALU result is accepted.
    always_comb begin
        sel           = 1'b0;
        sel_wad       = R0;
        sel_wdat      = '0;
        skid_full_nxt = skid_full;
        skid_rfd_nxt  = skid_rfd;
        skid_dat_nxt  = skid_dat;

        if (load_sel) begin
            sel      = 1'b1;
            sel_wad  = pend_rfd;
            sel_wdat = lsu_data_i;
            if (exec_acc) begin
                skid_full_nxt = 1'b1;
                skid_rfd_nxt  = exec_rfd_i;
                skid_dat_nxt  = exec_result_i;
            end
        end else if (skid_full) begin
            sel           = 1'b1;
            sel_wad       = skid_rfd;
            sel_wdat      = skid_dat;
            skid_full_nxt = 1'b0;
        end else if (exec_acc) begin
            sel      = 1'b1;
            sel_wad  = exec_rfd_i;
            sel_wdat = exec_result_i;
        end
    end

    // Load tracking FSM. An issue while already pending is only honoured together with the
    // return of the previous load; a lone issue in PEND is a protocol violation and ignored.
    always_comb begin
        state_nxt    = state;
        pend_rfd_nxt = pend_rfd;
        case (state)
            IDLE: begin
                if (lsu_issue_i && (lsu_rfd_i != R0)) begin
                    state_nxt    = PEND;
                    pend_rfd_nxt = lsu_rfd_i;
                end
            end
            PEND: begin
                if (lsu_valid_i) begin
                    if (lsu_issue_i && (lsu_rfd_i != R0)) begin
                        pend_rfd_nxt = lsu_rfd_i;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_rfd  <= R0;
            skid_full <= 1'b0;
            skid_rfd  <= R0;
            skid_dat  <= '0;
            rf_we_o   <= 1'b0;
            rf_wad_o  <= R0;
            rf_wdat_o <= '0;
        end else begin
            state     <= state_nxt;
            pend_rfd  <= pend_rfd_nxt;
            skid_full <= skid_full_nxt;
            skid_rfd  <= skid_rfd_nxt;
            skid_dat  <= skid_dat_nxt;
            // r0 writes complete their handshake but never assert the enable.
            rf_we_o   <= sel && (sel_wad != R0);
            if (sel) begin
                rf_wad_o  <= sel_wad;
                rf_wdat_o <= sel_wdat;
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_rf_wb_sequencer_cappuccino.sv
module tb_mor1kx_rf_wb_sequencer_cappuccino;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          exec_valid;
    logic [AW-1:0] exec_rfd;
    logic [W-1:0]  exec_result;
    logic          exec_ready;
    logic          lsu_issue;
    logic [AW-1:0] lsu_rfd;
    logic          lsu_valid;
    logic [W-1:0]  lsu_data;
    logic          lsu_busy;
    logic [AW-1:0] dec_rfa_adr;
    logic [AW-1:0] dec_rfb_adr;
    logic          dec_rfa_used;
    logic          dec_rfb_used;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_wad;
    logic [W-1:0]  rf_wdat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mor1kx_rf_wb_sequencer_cappuccino #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_RF_ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exec_valid_i   (exec_valid),
        .exec_rfd_i     (exec_rfd),
        .exec_result_i  (exec_result),
        .exec_ready_o   (exec_ready),
        .lsu_issue_i    (lsu_issue),
        .lsu_rfd_i      (lsu_rfd),
        .lsu_valid_i    (lsu_valid),
        .lsu_data_i     (lsu_data),
        .lsu_busy_o     (lsu_busy),
        .dec_rfa_adr_i  (dec_rfa_adr),
        .dec_rfb_adr_i  (dec_rfb_adr),
        .dec_rfa_used_i (dec_rfa_used),
        .dec_rfb_used_i (dec_rfb_used),
        .stall_o        (stall),
        .rf_we_o        (rf_we),
        .rf_wad_o       (rf_wad),
        .rf_wdat_o      (rf_wdat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exec_valid   = 1'b0;
        exec_rfd     = '0;
        exec_result  = '0;
        lsu_issue    = 1'b0;
        lsu_rfd      = '0;
        lsu_valid    = 1'b0;
        lsu_data     = '0;
        dec_rfa_adr  = '0;
        dec_rfb_adr  = '0;
        dec_rfa_used = 1'b0;
        dec_rfb_used = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [AW-1:0] wad,
                          input logic [W-1:0] wdat);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({tag, "_wad"}, 32'(rf_wad), 32'(wad));
            chk({tag, "_wdat"}, rf_wdat, wdat);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_wad", 32'(rf_wad), 0);
        chk("rst_wdat", rf_wdat, 0);
        chk("rst_busy", 32'(lsu_busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ready", 32'(exec_ready), 1);

        // single ALU write, one-cycle latency, one cycle wide
        exec_valid = 1'b1; exec_rfd = 5'd3; exec_result = 32'h1234;
        #1 chk("alu_ready", 32'(exec_ready), 1);
        tick(); clear_inputs(); #1;
        chk_wr("alu_wr", 1'b1, 5'd3, 32'h1234);
        chk("alu_ready_after", 32'(exec_ready), 1);
        tick();
        chk_wr("alu_idle", 1'b0, 5'd0, 32'h0);

        // load return collides with ALU result: load first, skid second
        lsu_issue = 1'b1; lsu_rfd = 5'd5;
        tick(); clear_inputs(); #1;
        chk("ld_busy", 32'(lsu_busy), 1);
        exec_valid = 1'b1; exec_rfd = 5'd7; exec_result = 32'hA;
        lsu_valid = 1'b1; lsu_data = 32'hB;
        #1 chk("col_ready", 32'(exec_ready), 1);
        tick(); clear_inputs();
        dec_rfa_adr = 5'd7; dec_rfa_used = 1'b1; #1;
        chk_wr("col_ld", 1'b1, 5'd5, 32'hB);
        chk("col_ready_skid", 32'(exec_ready), 0);
        chk("col_busy", 32'(lsu_busy), 0);
        chk("col_stall_skid", 32'(stall), 1);
        tick(); clear_inputs(); #1;
        chk_wr("col_skid", 1'b1, 5'd7, 32'hA);
        chk("col_ready_drain", 32'(exec_ready), 1);
        tick();
        chk_wr("col_idle", 1'b0, 5'd0, 32'h0);

        // RAW stall against pending load, then WAW block on exec
        lsu_issue = 1'b1; lsu_rfd = 5'd5;
        tick(); clear_inputs();
        dec_rfa_adr = 5'd5; dec_rfa_used = 1'b1;
        #1 chk("raw_a_used", 32'(stall), 1);
        dec_rfa_used = 1'b0;
        #1 chk("raw_a_unused", 32'(stall), 0);
        dec_rfb_adr = 5'd5; dec_rfb_used = 1'b1;
        #1 chk("raw_b_used", 32'(stall), 1);
        dec_rfb_adr = 5'd6;
        #1 chk("raw_b_other", 32'(stall), 0);
        dec_rfb_used = 1'b0;
        exec_valid = 1'b1; exec_rfd = 5'd5; exec_result = 32'h55;
        #1 chk("waw_ready0", 32'(exec_ready), 0);
        tick();
        chk("waw_ready1", 32'(exec_ready), 0);
        chk_wr("waw_nowr", 1'b0, 5'd0, 32'h0);
        lsu_valid = 1'b1; lsu_data = 32'h66;
        #1 chk("waw_ready_ret", 32'(exec_ready), 0);
        tick(); lsu_valid = 1'b0; lsu_data = '0; #1;
        chk_wr("waw_ld", 1'b1, 5'd5, 32'h66);
        chk("waw_ready_free", 32'(exec_ready), 1);
        tick(); clear_inputs();
        dec_rfa_adr = 5'd5; dec_rfa_used = 1'b1; #1;
        chk_wr("waw_exec", 1'b1, 5'd5, 32'h55);
        chk("raw_after_wr", 32'(stall), 0);
        tick(); clear_inputs(); #1;
        chk_wr("waw_idle", 1'b0, 5'd0, 32'h0);

        // r0 handling
        exec_valid = 1'b1; exec_rfd = 5'd0; exec_result = 32'h99;
        #1 chk("r0_ready", 32'(exec_ready), 1);
        tick(); clear_inputs(); #1;
        chk("r0_we", 32'(rf_we), 0);
        lsu_issue = 1'b1; lsu_rfd = 5'd0;
        tick(); clear_inputs(); #1;
        chk("r0_busy", 32'(lsu_busy), 0);

        // load data in IDLE is ignored
        lsu_valid = 1'b1; lsu_data = 32'hDD;
        tick(); clear_inputs(); #1;
        chk("idle_ret_we", 32'(rf_we), 0);

        // back-to-back loads: return + issue in same cycle keeps PEND with new rfd
        lsu_issue = 1'b1; lsu_rfd = 5'd9;
        tick(); clear_inputs();
        lsu_issue = 1'b1; lsu_rfd = 5'd11;      // lone issue while PEND: ignored
        tick(); clear_inputs();
        lsu_valid = 1'b1; lsu_data = 32'hC1; lsu_issue = 1'b1; lsu_rfd = 5'd10;
        tick(); clear_inputs(); #1;
        chk_wr("b2b_first", 1'b1, 5'd9, 32'hC1);
        chk("b2b_busy", 32'(lsu_busy), 1);
        lsu_valid = 1'b1; lsu_data = 32'hC2;
        tick(); clear_inputs(); #1;
        chk_wr("b2b_second", 1'b1, 5'd10, 32'hC2);
        chk("b2b_busy_done", 32'(lsu_busy), 0);

        // reset while a load is pending
        lsu_issue = 1'b1; lsu_rfd = 5'd6;
        tick(); clear_inputs(); #1;
        chk("rstp_busy", 32'(lsu_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lsu_valid = 1'b1; lsu_data = 32'hEE;
        dec_rfa_adr = 5'd6; dec_rfa_used = 1'b1;
        #1 chk("rstp_stall", 32'(stall), 0);
        tick(); clear_inputs(); #1;
        chk("rstp_we", 32'(rf_we), 0);
        chk("rstp_wad", 32'(rf_wad), 0);
        chk("rstp_wdat", rf_wdat, 0);
        chk("rstp_busy0", 32'(lsu_busy), 0);
        chk("rstp_ready", 32'(exec_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
